// File: rtl/serializer_pkg.sv
// Shared definitions for the nibble serializer: FSM encoding, widths and
// select-order helpers. Bit order is chosen by SERIALIZER_MSB_FIRST_EN
// (defined: MSB first; undefined: LSB first).
package serializer_pkg;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

`ifdef SERIALIZER_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_SEL = 2'd3;
  localparam logic [SEL_W-1:0] LAST_SEL  = 2'd0;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    return sel - 2'd1;
  endfunction
`else
  localparam logic [SEL_W-1:0] FIRST_SEL = 2'd0;
  localparam logic [SEL_W-1:0] LAST_SEL  = 2'd3;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    return sel + 2'd1;
  endfunction
`endif

endpackage

// File: rtl/nibble_serializer_mux.sv
// Existing 4:1 bit multiplexer used as the serializer's output stage.
module Mux_4_1 (
  input  logic [3:0] inputData,
  input  logic [1:0] selection,
  output logic       outputData
);

  // Pick one bit of the word by the select value.
  always_comb begin
    outputData = inputData[selection];
  end

endmodule

// File: rtl/nibble_serializer.sv
// Nibble serializer: accepts a 4-bit word over valid/ready, then steps the
// mux select through all four positions emitting one bit per accepted beat.
// Optional macro SERIALIZER_MSB_FIRST_EN selects MSB-first bit order.
module nibble_serializer
  import serializer_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic [SEL_W-1:0]  selection,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        gap_cnt;
  logic              at_last;

  assign at_last = (selection == LAST_SEL);

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept in IDLE, leave SHIFT on the last accepted beat,
  // leave GAP once the idle window has elapsed.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (out_ready && at_last) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the word, walk the select, time the gap, count words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      selection  <= '0;
      gap_cnt    <= '0;
      word_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            selection <= FIRST_SEL;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (at_last) begin
              word_count <= word_count + 1'b1;
              gap_cnt    <= '0;
            end else begin
              selection <= next_sel(selection);
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SHIFT);
  assign out_last  = (state == SHIFT) && at_last;
  assign busy      = (state != IDLE);

  Mux_4_1 u_mux (
    .inputData  (data_q),
    .selection  (selection),
    .outputData (out_bit)
  );

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer. Bit order expectations follow
// SERIALIZER_MSB_FIRST_EN. A second instance with GAP_CYCLES=3 covers the gap.
module tb_nibble_serializer;

`ifdef SERIALIZER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  typedef struct {
    logic       b;
    logic [1:0] s;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_bit;
  logic       out_last;
  logic [1:0] selection;
  logic       busy;
  logic [7:0] word_count;

  logic       in_valid1 = 1'b0;
  logic [3:0] in_data1 = 4'd0;
  logic       in_ready1;
  logic       out_valid1;
  logic       out_bit1;
  logic       out_last1;
  logic [1:0] selection1;
  logic       busy1;
  logic [7:0] word_count1;

  beat_t sb[$];
  int    expWords = 0;
  int    checkCount = 0;
  int    passCount = 0;

  always #5 clk = ~clk;

  nibble_serializer #(.GAP_CYCLES(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
    .selection(selection), .busy(busy), .word_count(word_count)
  );

  nibble_serializer #(.GAP_CYCLES(3), .CNT_W(8)) dut_gap (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_bit(out_bit1), .out_last(out_last1),
    .selection(selection1), .busy(busy1), .word_count(word_count1)
  );

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one word (called just after a rising edge) and queue its four beats.
  task automatic applyStimulus(input logic [3:0] word);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("handshake_timeout", 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < 4; k++) begin
        beat_t e;
        int    idx;
        idx = MSB_FIRST ? (3 - k) : k;
        e.b = word[idx];
        e.s = 2'(idx);
        e.l = (k == 3);
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: every accepted beat must match the next queued beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        checkOutput("beat_bit", 32'(out_bit), 32'(e.b));
        checkOutput("beat_sel", 32'(selection), 32'(e.s));
        checkOutput("beat_last", 32'(out_last), 32'(e.l));
        if (e.l) expWords++;
      end
    end
  end

  // Wait (bounded) until all queued beats have been consumed and the DUT is idle.
  task automatic drain(input string tag);
    int waited = 0;
    while ((sb.size() != 0 || !in_ready) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput(tag, 32'(sb.size() == 0 && in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] holdSel;
    int         lowCycles;
    int         waited;

    // Reset state
    rst = 1'b1;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_bit", 32'(out_bit), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_selection", 32'(selection), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Reset mid-word drops the word without counting it
    applyStimulus(4'b1101);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_word_count", 32'(word_count), 32'd0);
    sb.delete();
    expWords = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic word, first-beat latency and return of in_ready
    applyStimulus(4'b1011);
    checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("beat4_out_last", 32'(out_last), 32'd1);
    checkOutput("beat4_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("word1_in_ready", 32'(in_ready), 32'd1);
    checkOutput("word1_count", 32'(word_count), 32'd1);
    checkOutput("word1_busy", 32'(busy), 32'd0);

    // Backpressure on the second beat of 4'b0110
    applyStimulus(4'b0110);
    @(posedge clk); #1;
    holdSel = MSB_FIRST ? 2'd2 : 2'd1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_bit", 32'(out_bit), 32'd1);
      checkOutput("bp_selection", 32'(selection), 32'(holdSel));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp_drain");
    checkOutput("bp_word_count", 32'(word_count), 32'(expWords));

    // Wrap of the word counter with random words
    while (expWords + sb.size() / 4 < 256) begin
      applyStimulus(4'($urandom_range(0, 15)));
    end
    drain("wrap_drain");
    checkOutput("wrap_expwords", 32'(expWords), 32'd256);
    checkOutput("wrap_word_count", 32'(word_count), 32'd0);
    applyStimulus(4'b1001);
    drain("post_wrap_drain");
    checkOutput("post_wrap_count", 32'(word_count), 32'd1);

    // Gap instance: two back-to-back words with in_valid held
    in_valid1 = 1'b1;
    in_data1  = 4'b1011;
    @(negedge clk);
    checkOutput("gap_first_ready", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    in_data1 = 4'b0110;
    waited = 0;
    @(negedge clk);
    while (!(out_valid1 && out_last1) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("gap_saw_last", 32'(out_valid1 && out_last1), 32'd1);
    lowCycles = 0;
    @(negedge clk);
    while (!in_ready1 && lowCycles < 20) begin
      lowCycles++;
      checkOutput("gap_out_valid", 32'(out_valid1), 32'd0);
      checkOutput("gap_busy", 32'(busy1), 32'd1);
      @(negedge clk);
    end
    checkOutput("gap_low_cycles", 32'(lowCycles), 32'd3);
    checkOutput("gap_word_count", 32'(word_count1), 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    checkOutput("gap_second_valid", 32'(out_valid1), 32'd1);
    checkOutput("gap_second_sel", 32'(selection1), MSB_FIRST ? 32'd3 : 32'd0);
    checkOutput("gap_second_bit", 32'(out_bit1), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
